// File: rtl/lzc_norm_scheduler_if.sv
// Request/response bundle for lzc_norm_scheduler: NUM_REQ valid/ready request
// lanes in, one tagged normalisation result out.
interface lzc_norm_scheduler_if #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 22,
  parameter int COUNT_WIDTH = 5,
  parameter int ID_WIDTH    = 2
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [ID_WIDTH-1:0]           rsp_id;
  logic [COUNT_WIDTH-1:0]        rsp_count;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic                          rsp_zero;

  // Requesters plus the downstream consumer.
  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_count, rsp_data, rsp_zero
  );

  // The scheduler itself.
  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_count, rsp_data, rsp_zero
  );
endinterface

// File: rtl/lzc_norm_scheduler.sv
// Round-robin shared leading-zero-count / normalise datapath with one registered
// response stage. Define LZC_SCHED_STATS_EN to add grant/stall counters.
module lzc_norm_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 22,
  parameter int COUNT_WIDTH = 5,
  parameter int ID_WIDTH    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  lzc_norm_scheduler_if.slave  bus
`ifdef LZC_SCHED_STATS_EN
  ,
  output logic [31:0]          stat_grants,
  output logic [31:0]          stat_stalls
`endif
);

  logic [ID_WIDTH-1:0]    ptr_q, ptr_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [ID_WIDTH-1:0]    rsp_id_q, rsp_id_d;
  logic [COUNT_WIDTH-1:0] rsp_count_q, rsp_count_d;
  logic [DATA_WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic                   rsp_zero_q, rsp_zero_d;

  logic                   load_ok;
  logic                   grant_found;
  logic                   grant;
  logic [ID_WIDTH-1:0]    grant_idx;
  logic [NUM_REQ-1:0]     req_ready;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic [COUNT_WIDTH-1:0] lz_count;
  logic                   lz_found;

  assign load_ok = !rsp_valid_q || bus.rsp_ready;

  // Search ptr, ptr+1, ... (mod NUM_REQ); the first valid lane wins.
  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin : arbiter
    int                  idx;
    logic [ID_WIDTH-1:0] idx_c;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    idx_c       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx   = (int'(ptr_q) + i) % NUM_REQ;
      idx_c = ID_WIDTH'(idx);
      if (!grant_found && bus.req_valid[idx_c]) begin
        grant_found = 1'b1;
        grant_idx   = idx_c;
      end
    end
  end

  // Ready only ever asserts on a valid lane, so grant is the handshake itself.
  assign grant     = grant_found && load_ok && !rst;
  assign req_ready = grant ? (NUM_REQ'(1) << grant_idx) : '0;
  assign sel_data  = bus.req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin : priority_encoder
    lz_count = COUNT_WIDTH'(DATA_WIDTH);
    lz_found = 1'b0;
    for (int b = DATA_WIDTH - 1; b >= 0; b--) begin
      if (!lz_found && sel_data[b]) begin
        lz_found = 1'b1;
        lz_count = COUNT_WIDTH'(DATA_WIDTH - 1 - b);
      end
    end
  end

  always_comb begin : next_state
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_count_d = rsp_count_q;
    rsp_data_d  = rsp_data_q;
    rsp_zero_d  = rsp_zero_q;
    if (grant) begin
      ptr_d       = (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + ID_WIDTH'(1);
      rsp_valid_d = 1'b1;
      rsp_id_d    = grant_idx;
      rsp_count_d = lz_count;
      rsp_data_d  = sel_data << lz_count;
      rsp_zero_d  = !lz_found;
    end else if (bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge value of its peers, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_count_q <= '0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_count_q <= rsp_count_d;
      rsp_data_q  <= rsp_data_d;
      rsp_zero_q  <= rsp_zero_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_count = rsp_count_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_zero  = rsp_zero_q;

`ifdef LZC_SCHED_STATS_EN
  logic [31:0] grants_q, stalls_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      grants_q <= '0;
      stalls_q <= '0;
    end else if (grant) begin
      grants_q <= grants_q + 32'd1;
    end else if (|bus.req_valid) begin
      stalls_q <= stalls_q + 32'd1;
    end
  end

  assign stat_grants = grants_q;
  assign stat_stalls = stalls_q;
`endif

endmodule

// File: doc/lzc_norm_scheduler.md
# lzc_norm_scheduler

Round-robin scheduler that shares a single leading-zero-count / normalize-shift datapath among `NUM_REQ` requesters in the fpmul/fpadd normalization path. It accepts one request per cycle through valid/ready handshakes and computes the leading-zero count and the left-normalized mantissa. Results go out through one registered response port, tagged with the requester index. It replaces the per-unit combinational counters with a single shared instance and throttles requesters under downstream backpressure.

## Interface
- `NUM_REQ`, 4 — number of requesters, 2..8
- `DATA_WIDTH`, 22 — mantissa width per request
- `COUNT_WIDTH`, 5 — count width; must satisfy 2^COUNT_WIDTH > DATA_WIDTH
- `ID_WIDTH`, 2 — requester tag width, equal to max(1, clog2(NUM_REQ))

Ports:
- `clk` input 1 — clock; all logic on rising edge
- `rst` input 1 — synchronous, active-high reset
- `req_valid` input NUM_REQ — per-requester request valid
- `req_ready` output NUM_REQ — per-requester accept, one-hot or zero
- `req_data` input NUM_REQ*DATA_WIDTH — requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- `rsp_valid` output 1 — response valid
- `rsp_ready` input 1 — downstream accept
- `rsp_id` output ID_WIDTH — index of the served requester
- `rsp_count` output COUNT_WIDTH — leading zeros of the served data
- `rsp_data` output DATA_WIDTH — served data shifted left by `rsp_count`
- `rsp_zero` output 1 — served data was all zero
- `stat_grants` output 32 — present only with `LZC_SCHED_STATS_EN`
- `stat_stalls` output 32 — present only with `LZC_SCHED_STATS_EN`

## Operation
- **Output stage:** one register stage holds the result. It can load when `load_ok = !rsp_valid || rsp_ready`.
- **Arbitration:** round-robin pointer `ptr` (ID_WIDTH bits, reset 0).
  - When `load_ok`, the grant goes to the first requester with `req_valid` high, searching `ptr, ptr+1, … ptr+NUM_REQ-1` mod NUM_REQ.
  - `req_ready[g]` is high only for that granted index. The handshake completes when `req_valid[g] && req_ready[g]`.
  - `req_ready` is all-zero when `!load_ok` or when no request is valid.
  - `req_ready` depends combinationally on `req_valid`, `ptr`, `rsp_valid` and `rsp_ready`.
- **Pointer update:** after a grant to g, `ptr` becomes (g+1) mod NUM_REQ. With no grant, `ptr` holds.
- **Datapath:** count = number of zeros above the most significant 1. For all-zero data, count = DATA_WIDTH, `rsp_zero` = 1 and `rsp_data` = 0. Otherwise `rsp_data` = data << count, so its MSB is 1.
- **Output register update:**
  - On a handshake: `rsp_valid` is set to 1 and `rsp_id`, `rsp_count`, `rsp_data`, `rsp_zero` are loaded.
  - Else if `rsp_ready`: `rsp_valid` is cleared to 0.
  - Otherwise the register holds, and the payload stays stable while `rsp_valid && !rsp_ready`.
- **Reset values:** `rsp_valid`, `rsp_id`, `rsp_count`, `rsp_data`, `rsp_zero` and `ptr` are all 0. `req_ready` is all-zero during the reset cycle.
- **Reset mid-operation:** a pending response is discarded with no output.
- A requester must hold `req_valid` and `req_data` until served. The block does not check this.

## Timing
- Latency is 1 cycle: a handshake at edge N gives `rsp_valid` = 1 after edge N.
- Full throughput is one grant per cycle while `rsp_ready` = 1.
- Simultaneous response drain and new load in the same cycle is allowed (`load_ok` through `rsp_ready`).
- Under backpressure there are zero grants, and `rsp_*` is held across cycles.
- Fairness: a requester with continuous `req_valid` is served within NUM_REQ grants.
- Critical path: arbiter, then mux, then priority encoder, then barrel shift. No internal pipelining.

## Configuration
- `LZC_SCHED_STATS_EN` defined:
  - `stat_grants` increments on every handshake.
  - `stat_stalls` increments on every cycle where any `req_valid` is high and no handshake occurs.
  - Both counters reset to 0 on `rst` and wrap modulo 2^32.
- Not defined: both ports and counters are absent, and scheduler behaviour is identical.

## Test plan
- **Reset:** hold `rst` 3 cycles with all `req_valid` = 1 → `req_ready` = 0 and `rsp_valid` = 0 throughout; first grant after release goes to requester 0.
- **Datapath vectors:** single requester 1, data 0x000ABC (22-bit) → `rsp_count` = 10, `rsp_data` = 0x2AF000, `rsp_id` = 1 one cycle later. Data 0 → count 22, `rsp_zero` = 1. Data 0x200000 → count 0.
- **Round-robin fairness:** all 4 requesters valid continuously with `rsp_ready` = 1 → grant order 0,1,2,3,0,… and `rsp_valid` high every cycle.
- **Backpressure:** `rsp_ready` = 0 for 5 cycles with a response held → payload unchanged, no `req_ready`; when `rsp_ready` rises, drain and new load occur in the same cycle.
- **Pointer skip:** `ptr` = 2, only requesters 0 and 1 valid → grant 0, then 1, then `ptr` = 2.
- **Stats (with `LZC_SCHED_STATS_EN`):** 8 grants plus 3 stalled cycles → `stat_grants` = 8, `stat_stalls` = 3; `rst` → both 0.
